// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a first-word-fall-through FIFO.
// 8N1-style framing: start, Width data bits LSB first, stop.
module uart_tx_fifo #(
  parameter int Width      = 8,
  parameter int ClksPerBit = 868
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             empty_i,
  input  logic [Width-1:0] r_data_i,
  output logic             rd_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int IW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CW-1:0] LAST = CW'(ClksPerBit - 1);
  localparam logic [IW-1:0] TOP  = IW'(Width - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [Width-1:0] shift, shift_n;
  logic             tx, tx_n;
  logic             rd, done, last;

  assign last   = (cnt == LAST);
  assign rd_o   = rd & ~rst_i;
  assign tx_o   = tx;
  assign busy_o = (state != IDLE);
  assign done_o = done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    rd      = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty_i) begin
          rd      = 1'b1;
          shift_n = r_data_i;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (last) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (last) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (idx == TOP) state_n = STOP;
          else            idx_n   = idx + IW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (last) begin
          done  = 1'b1;
          cnt_n = '0;
          // Chain straight into the next start bit when a word waits
          if (!empty_i) begin
            rd      = 1'b1;
            shift_n = r_data_i;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: Width=8, ClksPerBit=4.
// Per-cycle traces are captured, then checked against expected frames.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       empty_i;
  logic [7:0] r_data_i;
  logic       rd_o, tx_o, busy_o, done_o;

  int checks   = 0;
  int failures = 0;

  logic       fifo_mode = 1'b0;
  logic [7:0] fq[$];

  logic tr_tx[$];
  logic tr_rd[$];
  logic tr_done[$];
  logic tr_busy[$];

  uart_tx_fifo #(.Width(8), .ClksPerBit(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .empty_i  (empty_i),
    .r_data_i (r_data_i),
    .rd_o     (rd_o),
    .tx_o     (tx_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    tr_tx.delete();
    tr_rd.delete();
    tr_done.delete();
    tr_busy.delete();
  endtask

  // One clock cycle: sample this cycle's outputs, then cross the edge
  task automatic tick();
    logic r;
    #1;
    r = rd_o;
    tr_tx.push_back(tx_o);
    tr_rd.push_back(rd_o);
    tr_done.push_back(done_o);
    tr_busy.push_back(busy_o);
    @(posedge clk);
    #1;
    if (fifo_mode) begin
      if (r && fq.size() > 0) void'(fq.pop_front());
      empty_i  = (fq.size() == 0);
      r_data_i = (fq.size() > 0) ? fq[0] : 8'h00;
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [39:0] frame_of(logic [7:0] b);
    logic [39:0] v;
    for (int c = 0; c < 40; c++) begin
      int k;
      k = c / 4;
      if (k == 0)      v[c] = 1'b0;
      else if (k == 9) v[c] = 1'b1;
      else             v[c] = b[k-1];
    end
    return v;
  endfunction

  function automatic logic [39:0] tx_at(int s);
    logic [39:0] v;
    for (int c = 0; c < 40; c++) v[c] = tr_tx[s+c];
    return v;
  endfunction

  function automatic int cnt(logic q[$], int s, int e);
    int n;
    n = 0;
    for (int i = s; i < e; i++) n += int'(q[i]);
    return n;
  endfunction

  initial begin
    rst_i    = 1'b1;
    empty_i  = 1'b0;
    r_data_i = 8'h00;

    // Reset / idle
    clr();
    ticks(3);
    chk("rst_tx", 64'(cnt(tr_tx, 0, 3)), 64'd3);
    chk("rst_rd", 64'(cnt(tr_rd, 0, 3)), 64'd0);
    rst_i   = 1'b0;
    empty_i = 1'b1;
    clr();
    ticks(100);
    chk("idle_rd", 64'(cnt(tr_rd, 0, 100)), 64'd0);
    chk("idle_tx", 64'(cnt(tr_tx, 0, 100)), 64'd100);
    chk("idle_busy", 64'(cnt(tr_busy, 0, 100)), 64'd0);

    // Single word 0xA5
    clr();
    r_data_i = 8'hA5;
    empty_i  = 1'b0;
    tick();
    empty_i = 1'b1;
    ticks(45);
    chk("a5_rd0", 64'(tr_rd[0]), 64'd1);
    chk("a5_rdn", 64'(cnt(tr_rd, 0, 46)), 64'd1);
    chk("a5_frame", 64'(tx_at(1)), 64'(frame_of(8'hA5)));
    chk("a5_done39", 64'(tr_done[40]), 64'd1);
    chk("a5_donen", 64'(cnt(tr_done, 0, 46)), 64'd1);
    chk("a5_busy", 64'(cnt(tr_busy, 41, 46)), 64'd0);
    chk("a5_busyin", 64'(cnt(tr_busy, 1, 41)), 64'd40);

    // Back-to-back from a preloaded FIFO
    clr();
    for (int i = 0; i < 8; i++) fq.push_back(8'(i));
    empty_i   = 1'b0;
    r_data_i  = 8'h00;
    fifo_mode = 1'b1;
    ticks(326);
    fifo_mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_frame%0d", k), 64'(tx_at(1 + 40*k)),
          64'(frame_of(8'(k))));
      chk($sformatf("b2b_rd%0d", k), 64'(tr_rd[40*k]), 64'd1);
    end
    chk("b2b_rdn", 64'(cnt(tr_rd, 0, 326)), 64'd8);
    chk("b2b_donen", 64'(cnt(tr_done, 0, 326)), 64'd8);
    chk("b2b_empty", 64'(empty_i), 64'd1);
    chk("b2b_idle", 64'(tr_busy[322]), 64'd0);

    // Data stability after pop
    clr();
    r_data_i = 8'h3C;
    empty_i  = 1'b0;
    tick();
    r_data_i = 8'hFF;
    empty_i  = 1'b1;
    ticks(45);
    chk("stab_frame", 64'(tx_at(1)), 64'(frame_of(8'h3C)));
    chk("stab_rdn", 64'(cnt(tr_rd, 0, 46)), 64'd1);

    // Reset mid-frame during data bit 3 of 0x55
    clr();
    r_data_i = 8'h55;
    empty_i  = 1'b0;
    tick();
    empty_i = 1'b1;
    ticks(18);
    chk("mid_pre_tx", 64'(tx_o), 64'd0);
    chk("mid_pre_busy", 64'(busy_o), 64'd1);
    rst_i   = 1'b1;
    empty_i = 1'b0;
    #1;
    chk("mid_rst_tx", 64'(tx_o), 64'd1);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_rd", 64'(rd_o), 64'd0);
    clr();
    ticks(2);
    chk("mid_rst_rdn", 64'(cnt(tr_rd, 0, 2)), 64'd0);
    rst_i    = 1'b0;
    r_data_i = 8'h96;
    clr();
    tick();
    empty_i = 1'b1;
    ticks(45);
    chk("mid_new_rd", 64'(tr_rd[0]), 64'd1);
    chk("mid_new_frame", 64'(tx_at(1)), 64'(frame_of(8'h96)));
    chk("mid_new_done", 64'(tr_done[40]), 64'd1);

    // Late refill during the stop bit
    clr();
    r_data_i = 8'hC3;
    empty_i  = 1'b0;
    tick();
    empty_i = 1'b1;
    ticks(37);
    empty_i  = 1'b0;
    r_data_i = 8'h5A;
    ticks(3);
    empty_i = 1'b1;
    ticks(45);
    chk("late_rd_early", 64'(cnt(tr_rd, 1, 40)), 64'd0);
    chk("late_rd40", 64'(tr_rd[40]), 64'd1);
    chk("late_done40", 64'(tr_done[40]), 64'd1);
    chk("late_frame1", 64'(tx_at(1)), 64'(frame_of(8'hC3)));
    chk("late_frame2", 64'(tx_at(41)), 64'(frame_of(8'h5A)));
    chk("late_rdn", 64'(cnt(tr_rd, 0, 86)), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial transmitter that drains the byte FIFO and sends each word as an asynchronous UART frame: 1 start bit, `Width` data bits LSB first, 1 stop bit, no parity. It sits directly downstream of the FIFO. It reads the FIFO's first-word-fall-through `r_data`/`empty` outputs and drives the FIFO's `rd` input. The serial output `tx_o` goes to the board pin.

## Interface
- `Width`, default 8: data bits per frame; must match the FIFO `Width`.
- `ClksPerBit`, default 868: clock cycles per bit (100 MHz / 115200 baud); legal range ≥ 2.
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; one clock, reset asynchronous and active-high.
- `empty_i`  in  1  FIFO empty flag; 0 means `r_data_i` holds a valid word.
- `r_data_i`  in  `Width`  FIFO head word (fall-through, valid while `empty_i`=0).
- `rd_o`  out  1  FIFO pop strobe; exactly one cycle per word consumed.
- `tx_o`  out  1  serial line; idle high; registered.
- `busy_o`  out  1  1 whenever a frame is in progress (state ≠ IDLE).
- `done_o`  out  1  one-cycle pulse in the last cycle of each stop bit.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Internal registers:
  - bit-cycle counter `$clog2(ClksPerBit)` bits, counting 0..ClksPerBit-1;
  - bit index `$clog2(Width)` bits;
  - shift register `Width` bits.
- IDLE:
  - `tx_o`=1, `busy_o`=0.
  - If `empty_i`=0, set `rd_o`=1 (combinational) for this cycle.
  - At the clock edge: load the shift register from `r_data_i`, clear the counter, go to START.
- START: `tx_o`=0 for ClksPerBit cycles, then go to DATA with bit index 0.
- DATA:
  - `tx_o`=shift[0] for ClksPerBit cycles, then shift right and increment the bit index.
  - After bit `Width-1`, go to STOP.
- STOP:
  - `tx_o`=1 for ClksPerBit cycles.
  - In the last STOP cycle (counter = ClksPerBit-1), `done_o`=1.
  - In that same cycle, if `empty_i`=0, `rd_o`=1 and the next edge loads the new word and enters START directly. This gives zero idle gap between frames.
  - Otherwise go to IDLE.
- `rd_o` = ~`rst_i` & ~`empty_i` & (state=IDLE or last STOP cycle).
  - It is never asserted during reset, never asserted while `empty_i`=1, and never more than once per frame.
- The word is captured at the pop edge. Later changes on `r_data_i` do not affect the frame in flight.
- Reset (asynchronous, including mid-frame):
  - state → IDLE, `tx_o` → 1, counters and shift register → 0, `busy_o`/`done_o`/`rd_o` → 0 immediately.
  - A partially sent word is lost; it is not re-popped.

## Timing
- Reset values: `tx_o`=1, `rd_o`=0, `busy_o`=0, `done_o`=0.
- Pop-to-line latency: `tx_o` falls at the same edge that samples `rd_o`=1, i.e. 1 cycle after `rd_o` rises.
- Frame length: exactly (Width+2)·ClksPerBit cycles, from the `tx_o` falling edge to the end of the stop bit.
- Bit k of the word occupies cycles [ (1+k)·ClksPerBit , (2+k)·ClksPerBit ) after that falling edge.
- `done_o` is high in cycle (Width+2)·ClksPerBit−1 of the frame. When the next pop occurs, `rd_o` is high in that same cycle.
- Back-to-back throughput: one word per (Width+2)·ClksPerBit cycles. From IDLE, 1 extra cycle precedes the first frame.
- `empty_i` rising mid-frame has no effect until the last STOP cycle.

## Test plan
Bench parameters: `Width`=8, ClksPerBit=4, 10 ns clock.

1. **Reset/idle.** Hold `rst_i`=1 with `empty_i`=0, then `empty_i`=1 after release.
   - During reset: `tx_o`=1 and `rd_o`=0.
   - After release: no `rd_o` pulse, `tx_o`=1 and `busy_o`=0 for 100 cycles.
2. **Single word.** Present `r_data_i`=0xA5, `empty_i`=0 for one pop, then `empty_i`=1.
   - Exactly 1 `rd_o` pulse.
   - `tx_o` = 0 then 1,0,1,0,0,1,0,1 then 1, each held 4 cycles (40 cycles total).
   - `done_o` high in frame cycle 39 only; `busy_o` 0 afterwards.
3. **Back-to-back.** Real FIFO (AddrBits=3) preloaded with 0x00..0x07.
   - 8 contiguous frames in 320 cycles, exactly 8 `rd_o` pulses, no idle-high gap between stop and start bits.
   - Decoded bytes 0x00..0x07 in order; FIFO `empty` high after the 8th pop.
4. **Data stability.** Change `r_data_i` to 0xFF one cycle after the pop of 0x3C with `empty_i`=1.
   - Serialized bits remain those of 0x3C (0,0,1,1,1,1,0,0).
5. **Reset mid-frame.** Assert `rst_i` during data bit 3 of 0x55.
   - `tx_o`=1 and `busy_o`=0 with no clock edge required.
   - After release with `empty_i`=0: a new pop and a fresh full 40-cycle frame.
6. **Late refill.** `empty_i` goes 1→0 during the stop bit of a frame.
   - Pop occurs in the last STOP cycle, simultaneous with `done_o`.
   - Next start bit begins on the following edge.
